pm1_controller: RTL and testbench
=================================

Name: pm1_controller

Overview:
- Sequences the modular-exponentiation engine (base-2 modexp: 2^exponent mod number) to run Pollard's p-1 factorisation of a 64-bit N.
- For k = 2..BOUND, issues exponent e_k = k! to the engine and reads back r_k = 2^(k!) mod N.
- After each step, computes g = gcd(r_k - 1, N) with an internal binary-GCD unit.
- Reports the first non-trivial factor, or failure.
- Sits between the top-level factoring FSM and the single shared engine instance.

Parameters:
- BOUND, 20, largest k tried; must be ≤ 20 so that k! fits in 64 bits.
- W, 64, width of N, exponent and result.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- n_in  in  W  number to factor, latched on start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at end of run.
- found  out  1  valid with done; 1 = non-trivial factor found.
- error  out  1  valid with done; 1 = illegal N (N < 4).
- factor  out  W  factor found (0 if none), held until next start.
- iter_k  out  5  k at termination, held.
- me_clear  out  1  active-high restart pulse to engine (engine's reset pin).
- me_start  out  1  held high while the engine operates.
- me_exponent  out  W  k! to engine.
- me_number  out  W  latched N.
- me_log_num  out  8  floor(log2 N)+1.
- me_done  in  1  engine finished; me_result valid.
- me_result  in  W  2^exponent mod N.

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0; accumulator E=1, k=2.
- FSM states: IDLE, CHECK, LOGN, ISSUE, WAIT, PREP, GCD, EVAL, FIN.
  - IDLE: on start, latch N, go to CHECK.
  - CHECK:
    - N < 4 → FIN with error=1.
    - N even → factor=2, found=1, iter_k=0, FIN; the engine is never touched.
    - Otherwise → LOGN.
  - LOGN: shift a copy of N right one bit per cycle to count its bit length; result goes to me_log_num. Takes ≤ 64 cycles. Then E=2, k=2, go to ISSUE.
  - ISSUE:
    - Drive me_exponent=E, me_number=N; hold me_log_num.
    - Assert me_clear for exactly 1 cycle with me_start=1.
    - Go to WAIT.
  - WAIT: keep me_start=1 and me_clear=0. When me_done=1, capture me_result into r and go to PREP. A me_done already high in the ISSUE cycle is ignored.
  - PREP:
    - d = r-1 if r ≥ 1; d = N-1 if r = 0.
    - Load GCD operands a=d, b=N.
    - Deassert me_start.
  - GCD: binary Stein algorithm, one step per cycle. gcd(0,N) = N. Terminates in ≤ 2W+2 cycles.
  - EVAL:
    - 1 < g < N → found=1, factor=g, FIN.
    - g == N → found=0, FIN (p-1 degenerate).
    - g == 1 and k == BOUND → found=0, FIN.
    - Otherwise → k=k+1, E=E*k (64×5 multiply, no overflow for BOUND ≤ 20), go to ISSUE.
  - FIN: iter_k=k (0 for the even-N case). done pulses 1 cycle, busy drops in the same cycle, return to IDLE.
- start while busy is ignored.
- Reset asserted mid-run aborts immediately: me_start=0, me_clear=0, outputs cleared.

Optional Feature:
- PM1_WATCHDOG_EN defined:
  - A 24-bit counter runs in WAIT and reloads on entry to WAIT.
  - If it reaches 2^24-1 before me_done, go to FIN with error=1, found=0, iter_k=current k, and drop me_start.
- Undefined: WAIT waits indefinitely; no counter is synthesised.

Test Plan:
- N=485, behavioural engine with 50–200 cycle random latency:
  - Exponents issued are 2, 6, 24.
  - Result: done with found=1, factor=5, iter_k=4, me_log_num=9.
- N=87 → single engine call (exponent 2, result 4, gcd(3,87)=3) → found=1, factor=3, iter_k=2, me_log_num=7.
- N=311 (prime) → 19 engine calls, k=2..20 → found=0, error=0, iter_k=20, factor=0.
- N=100 → factor=2, found=1, iter_k=0; me_clear and me_start never asserted. N=3 → error=1, found=0.
- Assert reset=0 during WAIT on the N=485 run → all outputs and me_* go to 0 asynchronously. Releasing reset and pulsing start gives the same result as a clean run. A start pulse issued while busy has no effect.
- PM1_WATCHDOG_EN defined, engine never asserts me_done → error=1 about 2^24 cycles after the first ISSUE, iter_k=2.

Source files
------------

// File: rtl/pm1_controller.sv
// rtl/pm1_controller.sv - Pollard p-1 sequencer driving the shared base-2 modexp engine.
// Optional WAIT-state watchdog enabled by defining PM1_WATCHDOG_EN.
`timescale 1ns/1ps
module pm1_controller #(
  parameter int BOUND = 20,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] n_in,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         error,
  output logic [W-1:0] factor,
  output logic [4:0]   iter_k,
  output logic         me_clear,
  output logic         me_start,
  output logic [W-1:0] me_exponent,
  output logic [W-1:0] me_number,
  output logic [7:0]   me_log_num,
  input  logic         me_done,
  input  logic [W-1:0] me_result
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_LOGN, S_ISSUE, S_WAIT, S_PREP, S_GCD, S_EVAL, S_FIN
  } state_t;

  state_t       state_q;
  logic [W-1:0] n_q, e_q, r_q, a_q, b_q, lsh_q;
  logic [7:0]   lcnt_q;
  logic [4:0]   k_q;
  logic         busy_q, done_q, found_q, error_q, me_clear_q, me_start_q;
  logic [W-1:0] factor_q, me_exp_q, me_num_q;
  logic [4:0]   iter_k_q;
  logic [7:0]   me_log_q;
`ifdef PM1_WATCHDOG_EN
  logic [23:0]  wd_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      e_q        <= W'(1);
      r_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      lsh_q      <= '0;
      lcnt_q     <= '0;
      k_q        <= 5'd2;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      error_q    <= 1'b0;
      factor_q   <= '0;
      iter_k_q   <= '0;
      me_clear_q <= 1'b0;
      me_start_q <= 1'b0;
      me_exp_q   <= '0;
      me_num_q   <= '0;
      me_log_q   <= '0;
`ifdef PM1_WATCHDOG_EN
      wd_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          n_q      <= n_in;
          busy_q   <= 1'b1;
          found_q  <= 1'b0;
          error_q  <= 1'b0;
          factor_q <= '0;
          iter_k_q <= '0;
          state_q  <= S_CHECK;
        end
        S_CHECK: begin
          if (n_q < W'(4)) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_FIN;
          end else if (!n_q[0]) begin
            found_q  <= 1'b1;
            factor_q <= W'(2);
            iter_k_q <= '0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_FIN;
          end else begin
            // N >= 4 so the top bit is already counted by starting at one.
            lsh_q   <= n_q >> 1;
            lcnt_q  <= 8'd1;
            state_q <= S_LOGN;
          end
        end
        S_LOGN: begin
          if (lsh_q == '0) begin
            me_log_q <= lcnt_q;
            e_q      <= W'(2);
            k_q      <= 5'd2;
            state_q  <= S_ISSUE;
          end else begin
            lsh_q  <= lsh_q >> 1;
            lcnt_q <= lcnt_q + 8'd1;
          end
        end
        S_ISSUE: begin
          me_exp_q   <= e_q;
          me_num_q   <= n_q;
          me_clear_q <= 1'b1;
          me_start_q <= 1'b1;
`ifdef PM1_WATCHDOG_EN
          wd_q       <= '0;
`endif
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          me_clear_q <= 1'b0;
          // While the engine is still being cleared its me_done is stale.
          if (me_done && !me_clear_q) begin
            r_q     <= me_result;
            state_q <= S_PREP;
          end
`ifdef PM1_WATCHDOG_EN
          else if (wd_q == 24'hFF_FFFF) begin
            error_q    <= 1'b1;
            found_q    <= 1'b0;
            iter_k_q   <= k_q;
            me_start_q <= 1'b0;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_FIN;
          end else begin
            wd_q <= wd_q + 24'd1;
          end
`endif
        end
        S_PREP: begin
          a_q        <= (r_q == '0) ? n_q - W'(1) : r_q - W'(1);
          b_q        <= n_q;
          me_start_q <= 1'b0;
          state_q    <= S_GCD;
        end
        // N is odd, so b stays odd and no common power of two is tracked.
        S_GCD: begin
          if (a_q == '0) begin
            state_q <= S_EVAL;
          end else if (!a_q[0]) begin
            a_q <= a_q >> 1;
          end else if (a_q >= b_q) begin
            a_q <= (a_q - b_q) >> 1;
          end else begin
            a_q <= (b_q - a_q) >> 1;
            b_q <= a_q;
          end
        end
        S_EVAL: begin
          if (b_q > W'(1) && b_q < n_q) begin
            found_q  <= 1'b1;
            factor_q <= b_q;
            iter_k_q <= k_q;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_FIN;
          end else if (b_q == n_q || k_q == 5'(BOUND)) begin
            iter_k_q <= k_q;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_FIN;
          end else begin
            k_q     <= k_q + 5'd1;
            e_q     <= e_q * W'(k_q + 5'd1);
            state_q <= S_ISSUE;
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign error       = error_q;
  assign factor      = factor_q;
  assign iter_k      = iter_k_q;
  assign me_clear    = me_clear_q;
  assign me_start    = me_start_q;
  assign me_exponent = me_exp_q;
  assign me_number   = me_num_q;
  assign me_log_num  = me_log_q;

endmodule

// File: tb/tb_pm1_controller.sv
// tb/tb_pm1_controller.sv - randomized bench for pm1_controller against a p-1 reference model.
`timescale 1ns/1ps
module tb_pm1_controller;

  logic        clk, reset, start;
  logic [63:0] n_in;
  logic        busy, done, found, error, me_clear, me_start, me_done;
  logic [63:0] factor, me_exponent, me_number, me_result;
  logic [4:0]  iter_k;
  logic [7:0]  me_log_num;

  pm1_controller #(.BOUND(20), .W(64)) dut (
    .clk(clk), .reset(reset), .start(start), .n_in(n_in),
    .busy(busy), .done(done), .found(found), .error(error),
    .factor(factor), .iter_k(iter_k), .me_clear(me_clear), .me_start(me_start),
    .me_exponent(me_exponent), .me_number(me_number), .me_log_num(me_log_num),
    .me_done(me_done), .me_result(me_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] modpow2(logic [63:0] e, logic [63:0] m);
    logic [127:0] r, b, ee;
    r = 1; b = 128'(2) % 128'(m); ee = 128'(e);
    while (ee != 0) begin
      if (ee[0]) r = (r * b) % 128'(m);
      b = (b * b) % 128'(m);
      ee = ee >> 1;
    end
    return r[63:0];
  endfunction

  function automatic logic [63:0] gcd_ref(logic [63:0] x, logic [63:0] y);
    logic [63:0] t;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  // Reference model results
  logic [63:0] exp_q[$];
  logic [63:0] mon_q[$];
  logic        exp_found, exp_err, exp_odd;
  logic [63:0] exp_factor;
  int          exp_iter, exp_logn;

  task automatic model(input logic [63:0] n);
    logic [63:0] e, r, d, g;
    exp_q.delete();
    exp_found = 0; exp_err = 0; exp_factor = 0; exp_iter = 0; exp_logn = 0; exp_odd = 0;
    if (n < 4) begin
      exp_err = 1;
    end else if (n % 2 == 0) begin
      exp_found = 1; exp_factor = 2;
    end else begin
      exp_odd = 1;
      for (int i = 0; i < 64; i++) if ((n >> i) != 0) exp_logn = i + 1;
      e = 1;
      for (int k = 2; k <= 20; k++) begin
        e = e * 64'(k);
        exp_q.push_back(e);
        r = modpow2(e, n);
        d = (r == 0) ? n - 1 : r - 1;
        g = gcd_ref(d, n);
        exp_iter = k;
        if (g > 1 && g < n) begin
          exp_found = 1; exp_factor = g;
          break;
        end
        if (g == n) break;
      end
    end
  endtask

  // Behavioural engine
  int lat_lo = 50, lat_hi = 200;
  int eng_cnt;
  bit eng_pending;
  initial begin
    me_done = 0; me_result = 0; eng_pending = 0; eng_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        me_done = 0; eng_pending = 0;
      end else if (me_clear) begin
        me_done = 0; eng_pending = 1;
        eng_cnt = $urandom_range(lat_hi, lat_lo);
      end else if (eng_pending && me_start) begin
        if (eng_cnt == 0) begin
          me_result = modpow2(me_exponent, me_number);
          me_done = 1; eng_pending = 0;
        end else begin
          eng_cnt--;
        end
      end
    end
  end

  // Compare process
  bit          active = 0;
  bit          saw_start;
  logic [63:0] cur_n;
  always @(negedge clk) begin
    if (active && reset) begin
      if (me_start) saw_start = 1;
      if (me_clear) begin
        if (mon_q.size() == 0) chk("unexpected_issue", 1, 0);
        else chk("issue_exponent", me_exponent, mon_q.pop_front());
        chk("issue_number", me_number, cur_n);
        chk("issue_start", me_start, 1);
      end
      if (done) begin
        chk("done_busy", busy, 0);
        chk("done_error", error, exp_err);
        chk("done_found", found, exp_found);
        chk("done_factor", factor, exp_factor);
        if (!exp_err) chk("done_iter_k", iter_k, 64'(exp_iter));
        if (exp_odd) chk("done_log_num", me_log_num, 64'(exp_logn));
        chk("calls_left", mon_q.size(), 0);
        chk("engine_used", saw_start, exp_q.size() > 0);
      end
    end
  end

  task automatic run_n(input logic [63:0] n, input int lo, input int hi, input bit spurious);
    bit got;
    model(n);
    mon_q = exp_q; saw_start = 0; cur_n = n; lat_lo = lo; lat_hi = hi;
    active = 1;
    @(negedge clk); n_in = n; start = 1;
    @(negedge clk); start = 0;
    chk("busy_after_start", busy, 1);
    if (spurious) begin
      repeat (30) @(negedge clk);
      n_in = 64'd87; start = 1;
      @(negedge clk); start = 0; n_in = n;
    end
    got = 0;
    for (int c = 0; c < 40000 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    if (!got) chk("timeout_done", 0, 1);
    repeat (2) @(negedge clk);
    active = 0;
    @(negedge clk);
  endtask

  initial begin
    bit got;
    logic [63:0] rn;
    reset = 0; start = 0; n_in = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_me_start", me_start, 0);
    chk("rst_factor", factor, 0);
    chk("rst_log_num", me_log_num, 0);
    reset = 1;
    @(negedge clk);

    // Pin the model with hand-computed expectations
    model(64'd485);
    chk("model485_calls", exp_q.size(), 3);
    chk("model485_e0", exp_q[0], 2);
    chk("model485_e1", exp_q[1], 6);
    chk("model485_e2", exp_q[2], 24);
    chk("model485_factor", exp_factor, 5);
    chk("model485_iter", exp_iter, 4);
    chk("model485_logn", exp_logn, 9);
    model(64'd87);
    chk("model87_factor", exp_factor, 3);
    chk("model87_iter", exp_iter, 2);
    chk("model87_logn", exp_logn, 7);
    model(64'd311);
    chk("model311_calls", exp_q.size(), 19);
    chk("model311_found", exp_found, 0);
    chk("model311_iter", exp_iter, 20);
    model(64'd100);
    chk("model100_factor", exp_factor, 2);
    chk("model100_calls", exp_q.size(), 0);
    model(64'd3);
    chk("model3_err", exp_err, 1);

    run_n(64'd485, 50, 200, 1);
    run_n(64'd87, 50, 200, 0);
    run_n(64'd311, 50, 200, 0);
    run_n(64'd100, 50, 200, 0);
    run_n(64'd3, 50, 200, 0);

    // Asynchronous reset while waiting on the engine
    model(64'd485);
    lat_lo = 150; lat_hi = 200;
    @(negedge clk); n_in = 64'd485; start = 1;
    @(negedge clk); start = 0;
    got = 0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk);
      if (me_start && !me_clear) got = 1;
    end
    if (!got) chk("timeout_wait", 0, 1);
    repeat (5) @(negedge clk);
    #2 reset = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_me_start", me_start, 0);
    chk("abort_me_clear", me_clear, 0);
    chk("abort_me_exponent", me_exponent, 0);
    chk("abort_me_number", me_number, 0);
    chk("abort_me_log_num", me_log_num, 0);
    chk("abort_done", done, 0);
    chk("abort_factor", factor, 0);
    @(negedge clk); reset = 1;
    repeat (2) @(negedge clk);
    run_n(64'd485, 50, 200, 0);

    // Randomized N with short engine latency
    for (int i = 0; i < 10; i++) begin
      case (i % 4)
        0: rn = {$urandom, $urandom} | 64'd1;
        1: rn = 64'($urandom_range(4095, 0));
        2: rn = 64'(($urandom_range(200, 3) | 1) * ($urandom_range(200, 3) | 1));
        default: rn = 64'($urandom_range(9, 0));
      endcase
      run_n(rn, 1, 8, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
